// File: rtl/ps2_keyboard_rx_if.sv
// PS/2 keyboard receiver bundle: raw connector lines in, decoded make code out.
// Latency: none (wiring only).
// Backpressure: none; the consumer must sample tasta while done is high.
//   ps2_clk / ps2_data : raw, asynchronous PS/2 lines (sink samples them)
//   tasta / done       : last accepted make code and its hold-high strobe
//   frame_err          : one-cycle pulse on a rejected or aborted frame
interface ps2_keyboard_rx_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] tasta;
    logic       done;
    logic       frame_err;

    // master: the receiver, which produces key codes from the connector lines
    modport master (input ps2_clk, ps2_data, output tasta, done, frame_err);
    // slave: the game logic / connector side
    modport slave  (output ps2_clk, ps2_data, input tasta, done, frame_err);
endinterface

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: sync + deglitch lines, deserialise 11-bit frames, strip E0/F0, emit make codes.
// Latency: done rises 2 clocks after the filtered stop-bit falling edge (sync/filter add 2+FILTER_LEN).
// Backpressure: none; a new make code overwrites tasta and restarts the DONE_HOLD window.
//   clock, reset (async active-low) ; kbd.ps2_clk/ps2_data raw inputs ;
//   kbd.tasta, kbd.done, kbd.frame_err outputs
module ps2_keyboard_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int DONE_HOLD      = 2
) (
    input  logic              clock,
    input  logic              reset,
    ps2_keyboard_rx_if.master kbd
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int HW = $clog2(DONE_HOLD + 1);

    // ---------------- input conditioning (index 0 = clock line, 1 = data line)
    logic [1:0]    raw;
    logic [1:0]    meta_q, sync_q, filt_q;
    logic [FW-1:0] flt_cnt_q [2];
    logic          clk_prev_q;
    logic          fall;
    logic          dat;

    assign raw = {kbd.ps2_data, kbd.ps2_clk};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            meta_q     <= 2'b11;
            sync_q     <= 2'b11;
            filt_q     <= 2'b11;
            clk_prev_q <= 1'b1;
            for (int i = 0; i < 2; i++) flt_cnt_q[i] <= '0;
        end else begin
            meta_q     <= raw;
            sync_q     <= meta_q;
            clk_prev_q <= filt_q[0];
            for (int i = 0; i < 2; i++) begin
                // any sample agreeing with the filtered value restarts the run
                if (sync_q[i] == filt_q[i]) begin
                    flt_cnt_q[i] <= '0;
                end else if (flt_cnt_q[i] == FW'(FILTER_LEN - 1)) begin
                    filt_q[i]    <= sync_q[i];
                    flt_cnt_q[i] <= '0;
                end else begin
                    flt_cnt_q[i] <= flt_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign fall = clk_prev_q & ~filt_q[0];
    assign dat  = filt_q[1];

    // ---------------- frame FSM
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} frame_st_t;
    frame_st_t     st_q, st_nxt;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shreg_q;
    logic          par_q;
    logic [TW-1:0] to_cnt_q;
    logic          timeout;
    logic          stop_ok, stop_bad;
    logic          byte_vld_q;
    logic [7:0]    byte_q;
    logic          frame_err_q;

    // a falling edge in the same cycle wins over the timeout
    assign timeout = (st_q != IDLE) && !fall && (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        st_nxt   = st_q;
        stop_ok  = 1'b0;
        stop_bad = 1'b0;
        if (fall) begin
            case (st_q)
                IDLE:    if (!dat) st_nxt = DATA;
                DATA:    if (bit_cnt_q == 3'd7) st_nxt = PARITY;
                PARITY:  st_nxt = STOP;
                STOP: begin
                    st_nxt = IDLE;
                    if (dat && ((^shreg_q) ^ par_q)) stop_ok  = 1'b1;
                    else                             stop_bad = 1'b1;
                end
                default: st_nxt = IDLE;
            endcase
        end else if (timeout) begin
            st_nxt = IDLE;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            st_q        <= IDLE;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            par_q       <= 1'b0;
            to_cnt_q    <= '0;
            byte_vld_q  <= 1'b0;
            byte_q      <= '0;
            frame_err_q <= 1'b0;
        end else begin
            st_q        <= st_nxt;
            to_cnt_q    <= (fall || st_nxt == IDLE) ? '0 : to_cnt_q + 1'b1;
            byte_vld_q  <= stop_ok;
            frame_err_q <= stop_bad | timeout;
            if (stop_ok) byte_q <= shreg_q;
            if (fall) begin
                if (st_q == IDLE) bit_cnt_q <= '0;
                if (st_q == DATA) begin
                    shreg_q   <= {dat, shreg_q[7:1]};   // LSB arrives first
                    bit_cnt_q <= bit_cnt_q + 1'b1;
                end
                if (st_q == PARITY) par_q <= dat;
            end
        end
    end

    // ---------------- prefix decoder
    typedef enum logic [1:0] {NORMAL, GOT_E0, GOT_F0} dec_st_t;
    dec_st_t dec_q, dec_nxt;
    logic    make_vld;

    always_comb begin
        dec_nxt  = dec_q;
        make_vld = 1'b0;
        if (byte_vld_q) begin
            case (dec_q)
                NORMAL: begin
                    if      (byte_q == 8'hE0) dec_nxt = GOT_E0;
                    else if (byte_q == 8'hF0) dec_nxt = GOT_F0;
                    else                      make_vld = 1'b1;
                end
                GOT_E0: begin
                    if (byte_q == 8'hF0) begin
                        dec_nxt = GOT_F0;
                    end else begin
                        make_vld = 1'b1;
                        dec_nxt  = NORMAL;
                    end
                end
                GOT_F0:  dec_nxt = NORMAL;   // released key code is swallowed
                default: dec_nxt = NORMAL;
            endcase
        end
    end

    // ---------------- make-code output with DONE_HOLD stretch
    logic [7:0]    tasta_q;
    logic          done_q;
    logic [HW-1:0] hold_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dec_q   <= NORMAL;
            tasta_q <= 8'h00;
            done_q  <= 1'b0;
            hold_q  <= '0;
        end else begin
            dec_q <= dec_nxt;
            if (make_vld) begin
                tasta_q <= byte_q;
                done_q  <= 1'b1;
                hold_q  <= HW'(DONE_HOLD - 1);
            end else if (done_q) begin
                if (hold_q == '0) done_q <= 1'b0;
                else              hold_q <= hold_q - 1'b1;
            end
        end
    end

    assign kbd.tasta     = tasta_q;
    assign kbd.done      = done_q;
    assign kbd.frame_err = frame_err_q;
endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Bench for ps2_keyboard_rx: directed scenarios plus randomized key events against a key-event model.
// Latency: n/a.
// Backpressure: n/a.
module tb_ps2_keyboard_rx;
    localparam int FL = 8;
    localparam int TO = 600;
    localparam int DH = 2;

    logic clock;
    logic reset;
    ps2_keyboard_rx_if kbd();

    ps2_keyboard_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO), .DONE_HOLD(DH)) dut (
        .clock (clock),
        .reset (reset),
        .kbd   (kbd)
    );

    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         t_stop = 0;
    int         hp = 20;
    int         err_seen = 0;
    int         err_exp = 0;
    logic [7:0] exp_q[$];

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc++;

    task automatic check(string tag, int obs, int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic wait_cyc(int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // one PS/2 bit: data set while the clock is high, device samples on the falling edge
    task automatic send_bit(logic d, bit glitch, bit is_stop);
        kbd.ps2_data = d;
        if (glitch) begin
            wait_cyc(hp / 2); kbd.ps2_clk = 1'b0; wait_cyc(3); kbd.ps2_clk = 1'b1;
            wait_cyc(hp - hp / 2 - 3);
        end else begin
            wait_cyc(hp);
        end
        kbd.ps2_clk = 1'b0;
        if (is_stop) t_stop = cyc;
        if (glitch) begin
            wait_cyc(hp / 2); kbd.ps2_clk = 1'b1; wait_cyc(3); kbd.ps2_clk = 1'b0;
            wait_cyc(hp - hp / 2 - 3);
        end else begin
            wait_cyc(hp);
        end
        kbd.ps2_clk = 1'b1;
    endtask

    task automatic send_frame(logic [7:0] b, bit bad_par = 1'b0, bit bad_stop = 1'b0,
                              bit glitch = 1'b0);
        hp = $urandom_range(20, 30);
        send_bit(1'b0, glitch, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i], glitch, 1'b0);
        send_bit((~^b) ^ bad_par, glitch, 1'b0);   // odd parity over data + parity
        send_bit(~bad_stop, glitch, 1'b1);
        kbd.ps2_data = 1'b1;
        wait_cyc(30);
    endtask

    // one key event: optional E0 prefix, optional F0 release marker, then the code
    task automatic send_key(logic [7:0] code, bit ext, bit brk);
        if (ext) send_frame(8'hE0);
        if (brk) send_frame(8'hF0);
        if (!brk) exp_q.push_back(code);
        send_frame(code);
    endtask

    // observer: every done assertion must match the next expected make code
    bit done_d = 1'b0;
    int run = 0;
    always @(negedge clock) begin
        if (!reset) begin
            done_d = 1'b0;
            run    = 0;
        end else begin
            if (kbd.frame_err) err_seen++;
            if (kbd.done && !done_d) begin
                check("make_pending", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) check("tasta", kbd.tasta, exp_q.pop_front());
                check("latency_window",
                      int'((cyc - t_stop) >= FL + 2 && (cyc - t_stop) <= FL + 8), 1);
                run = 1;
            end else if (kbd.done) begin
                run++;
            end else if (done_d) begin
                check("done_len", run, DH);
            end
            done_d = kbd.done;
        end
    end

    initial begin
        logic [7:0] code;
        logic [7:0] last_code;
        bit         brk, ext;

        kbd.ps2_clk  = 1'b1;
        kbd.ps2_data = 1'b1;
        reset        = 1'b0;
        wait_cyc(5);
        check("rst_tasta", kbd.tasta, 8'h00);
        check("rst_done", kbd.done, 0);
        check("rst_frame_err", kbd.frame_err, 0);
        reset = 1'b1;

        // idle lines
        wait_cyc(2000);
        check("idle_err", err_seen, 0);
        check("idle_tasta", kbd.tasta, 8'h00);
        check("idle_done", kbd.done, 0);

        // basic make code
        send_key(8'h29, 1'b0, 1'b0);
        check("space_tasta", kbd.tasta, 8'h29);
        check("space_drained", exp_q.size(), 0);

        // make/break, extended make, extended break
        send_key(8'h1C, 1'b0, 1'b0);
        send_key(8'h1C, 1'b0, 1'b1);
        check("after_break_tasta", kbd.tasta, 8'h1C);
        send_key(8'h75, 1'b1, 1'b0);
        check("ext_make_tasta", kbd.tasta, 8'h75);
        send_key(8'h75, 1'b1, 1'b1);
        check("ext_break_drained", exp_q.size(), 0);

        // parity error leaves outputs alone, next frame still decodes
        send_frame(8'h16, 1'b1);
        err_exp++;
        check("par_err_cnt", err_seen, err_exp);
        check("par_err_tasta", kbd.tasta, 8'h75);
        check("par_err_done", kbd.done, 0);
        send_key(8'h1E, 1'b0, 1'b0);
        check("after_par_tasta", kbd.tasta, 8'h1E);

        // stalled frame: start + 5 data bits then silence
        hp = 25;
        send_bit(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0, 1'b0);
        wait_cyc(TO + 100);
        err_exp++;
        check("timeout_err_cnt", err_seen, err_exp);
        send_key(8'h23, 1'b0, 1'b0);
        check("after_timeout_tasta", kbd.tasta, 8'h23);

        // short glitches on the clock line in every bit
        exp_q.push_back(8'h4B);
        send_frame(8'h4B, 1'b0, 1'b0, 1'b1);
        check("glitch_tasta", kbd.tasta, 8'h4B);
        check("glitch_err_cnt", err_seen, err_exp);

        // reset in the middle of a frame
        hp = 25;
        send_bit(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b0, 1'b0, 1'b0);
        #3 reset = 1'b0;
        #1;
        check("midrst_tasta", kbd.tasta, 8'h00);
        check("midrst_done", kbd.done, 0);
        check("midrst_frame_err", kbd.frame_err, 0);
        kbd.ps2_data = 1'b1;
        wait_cyc(5);
        reset = 1'b1;
        wait_cyc(20);
        send_key(8'h5A, 1'b0, 1'b0);
        check("after_rst_tasta", kbd.tasta, 8'h5A);

        // randomized key events with occasional corrupted frames
        last_code = 8'h5A;
        for (int k = 0; k < 20; k++) begin
            brk = ($urandom_range(0, 2) == 0);
            ext = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) == 0) begin
                code = last_code;                 // typematic repeat
            end else begin
                code = 8'($urandom_range(0, 255));
                while (code == 8'hE0 || code == 8'hF0) code = 8'($urandom_range(0, 255));
            end
            if ($urandom_range(0, 5) == 0) begin
                if ($urandom_range(0, 1) == 0) send_frame(8'($urandom_range(0, 255)), 1'b1, 1'b0);
                else                           send_frame(8'($urandom_range(0, 255)), 1'b0, 1'b1);
                err_exp++;
            end
            send_key(code, ext, brk);
            last_code = code;
        end

        wait_cyc(100);
        check("final_drained", exp_q.size(), 0);
        check("final_err_cnt", err_seen, err_exp);
        check("final_done_low", kbd.done, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
